// File: rtl/busio_arbiter_pkg.sv
// busio_arbiter_pkg
//   Shared definitions for the bus interface arbiter:
//   - request size encodings
//   - arbiter FSM state enum
//   - alignment check applied to every granted request
package busio_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // True when the request cannot be issued on the bus: a halfword on an odd
  // address, a word not on a 4-byte boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/busio_arbiter_if.sv
// busio_arbiter interfaces
//   busio_req_if : per-channel pipeline requests (flattened, channel i in
//                  slice i), completion/error pulses and shared load result.
//                  master = pipeline requesters, slave = arbiter.
//   busio_mem_if : single downstream memory bus.
//                  master = arbiter, slave = memory system.
interface busio_req_if #(
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 32
);
  logic [CHANNELS*ADDR_WIDTH-1:0] req_address;
  logic [CHANNELS*32-1:0]         req_store_data;
  logic [CHANNELS*2-1:0]          req_size;
  logic [CHANNELS-1:0]            req_signed;
  logic [CHANNELS-1:0]            req_load;
  logic [CHANNELS-1:0]            req_store;
  logic [CHANNELS-1:0]            req_ready;
  logic [CHANNELS-1:0]            req_error;
  logic [31:0]                    req_load_data;

  modport master (
    output req_address, req_store_data, req_size, req_signed, req_load, req_store,
    input  req_ready, req_error, req_load_data
  );

  modport slave (
    input  req_address, req_store_data, req_size, req_signed, req_load, req_store,
    output req_ready, req_error, req_load_data
  );
endinterface

interface busio_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   bus_address;
  logic [DATA_WIDTH-1:0]   bus_write_data;
  logic [DATA_WIDTH/8-1:0] bus_strobe;
  logic                    bus_read;
  logic                    bus_write;
  logic [DATA_WIDTH-1:0]   bus_read_data;
  logic                    bus_ready;

  modport master (
    output bus_address, bus_write_data, bus_strobe, bus_read, bus_write,
    input  bus_read_data, bus_ready
  );

  modport slave (
    input  bus_address, bus_write_data, bus_strobe, bus_read, bus_write,
    output bus_read_data, bus_ready
  );
endinterface

// File: rtl/busio_arbiter_lane_align.sv
// bus_lane_align
//   Combinational byte-lane steering between a 32-bit requester view and a
//   DATA_WIDTH-bit bus.
//   offset     : byte offset of the access inside one bus word
//   size       : SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   is_signed  : sign-extend byte/half loads
//   store_data : right-aligned store value
//   read_data  : raw bus read data
//   write_data : store value replicated into every lane of its size
//   strobe     : byte enables for the addressed lanes
//   load_data  : extracted and extended load result
module bus_lane_align
  import busio_arbiter_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]      offset,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [31:0]           store_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [STRB_W-1:0]     strobe,
  output logic [31:0]           load_data
);

  logic [31:0] shifted;

  always_comb begin
    write_data = '0;
    strobe     = '0;
    load_data  = '0;
    // Only the low 32 bits of the lane-shifted word can hold the result.
    shifted    = 32'(read_data >> {offset, 3'b000});
    case (size)
      SIZE_BYTE: begin
        write_data = {STRB_W{store_data[7:0]}};
        strobe     = STRB_W'(1) << offset;
        load_data  = is_signed ? {{24{shifted[7]}}, shifted[7:0]}
                               : {24'h0, shifted[7:0]};
      end
      SIZE_HALF: begin
        write_data = {(STRB_W/2){store_data[15:0]}};
        strobe     = STRB_W'(3) << offset;
        load_data  = is_signed ? {{16{shifted[15]}}, shifted[15:0]}
                               : {16'h0, shifted[15:0]};
      end
      default: begin
        write_data = {(STRB_W/4){store_data}};
        strobe     = STRB_W'(4'hF) << offset;
        load_data  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/busio_arbiter.sv
// busio_arbiter
//   Arbitrates CHANNELS pipeline request channels onto one memory bus with
//   fixed-priority or round-robin grant, byte-lane alignment, store strobes,
//   load extension and misalignment detection.
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-low
//   req   : busio_req_if.slave  (requests in, ready/error/load data out)
//   bus   : busio_mem_if.master (address/data/strobes/read/write out)
module busio_arbiter
  import busio_arbiter_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic       clk,
  input  logic       reset,
  busio_req_if.slave  req,
  busio_mem_if.master bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int GNT_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [GNT_W-1:0] gnt_t;

  state_t                state_q, state_d;
  gnt_t                  grant_q, last_grant_q, sel;
  logic                  any_active, sel_bad;
  logic                  error_q, write_q;
  logic [CHANNELS-1:0]   active;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [31:0]           wdata_q, rdata_q;

  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [STRB_W-1:0]     lane_strobe;
  logic [31:0]           lane_load;

  assign active = req.req_load | req.req_store;

  // Grant search: fixed priority starts at channel 0, round-robin starts
  // just after the last channel that was answered.
  always_comb begin : grant_pick
    int start;
    int idx;
    sel        = '0;
    any_active = 1'b0;
    start      = (ROUND_ROBIN != 0) ? ((int'(last_grant_q) + 1) % CHANNELS) : 0;
    idx        = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (start + k) % CHANNELS;
      if (!any_active && active[idx]) begin
        any_active = 1'b1;
        sel        = gnt_t'(idx);
      end
    end
  end

  assign sel_addr = req.req_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_size = req.req_size[int'(sel)*2 +: 2];
  assign sel_bad  = is_misaligned(sel_size, sel_addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_active) state_d = sel_bad ? RESPOND : ACCESS;
      ACCESS:  if (bus.bus_ready) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= gnt_t'(CHANNELS - 1);
      error_q      <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_active) begin
        grant_q <= sel;
        error_q <= sel_bad;
        // Load and store together is treated as a store.
        write_q <= req.req_store[sel];
      end
      if (state_q != RESPOND && state_d == RESPOND)
        last_grant_q <= (state_q == IDLE) ? sel : grant_q;
    end
  end

  // Request payload: captured at grant, read result captured on bus_ready.
  // Left unreset; every output derived from it is gated by the FSM state.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && any_active) begin
      addr_q   <= sel_addr;
      size_q   <= sel_size;
      signed_q <= req.req_signed[sel];
      wdata_q  <= req.req_store_data[int'(sel)*32 +: 32];
      rdata_q  <= '0;
    end else if (state_q == ACCESS && bus.bus_ready && !write_q) begin
      rdata_q  <= lane_load;
    end
  end

  bus_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .offset     (addr_q[OFF_W-1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .store_data (wdata_q),
    .read_data  (bus.bus_read_data),
    .write_data (lane_wdata),
    .strobe     (lane_strobe),
    .load_data  (lane_load)
  );

  always_comb begin
    bus.bus_read       = 1'b0;
    bus.bus_write      = 1'b0;
    bus.bus_address    = '0;
    bus.bus_write_data = '0;
    bus.bus_strobe     = '0;
    req.req_ready      = '0;
    req.req_error      = '0;
    req.req_load_data  = '0;
    if (state_q == ACCESS) begin
      bus.bus_read    = !write_q;
      bus.bus_write   = write_q;
      bus.bus_address = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      bus.bus_strobe  = lane_strobe;
      if (write_q) bus.bus_write_data = lane_wdata;
    end
    if (state_q == RESPOND) begin
      req.req_ready     = CHANNELS'(1) << grant_q;
      req.req_error     = error_q ? (CHANNELS'(1) << grant_q) : '0;
      req.req_load_data = rdata_q;
    end
  end

endmodule

// File: tb/tb_busio_arbiter.sv
// tb_busio_arbiter
//   Bench for busio_arbiter with two instances:
//   u_a : CHANNELS=2, DATA_WIDTH=32, fixed priority
//   u_b : CHANNELS=3, DATA_WIDTH=64, round-robin
//   A table of single-transfer vectors runs on u_a, followed by hand-written
//   sequences for contention, round-robin order, 64-bit lanes and reset
//   during an access.
module tb_busio_arbiter;
  import busio_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  busio_req_if #(.CHANNELS(2), .ADDR_WIDTH(32)) ra ();
  busio_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ba ();
  busio_req_if #(.CHANNELS(3), .ADDR_WIDTH(32)) rb ();
  busio_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bb ();

  busio_arbiter #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)) u_a (
    .clk(clk), .reset(reset), .req(ra), .bus(ba));
  busio_arbiter #(.CHANNELS(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ROUND_ROBIN(1)) u_b (
    .clk(clk), .reset(reset), .req(rb), .bus(bb));

  int errors = 0;
  int checks = 0;

  int          wait_a = 0, wait_b = 0;
  logic [31:0] rd_a = '0;
  logic [63:0] rd_b = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responders: bus_ready after wait_x wait states, one-cycle pulse.
  initial begin
    int cnt;
    cnt = 0;
    ba.bus_ready = 1'b0;
    ba.bus_read_data = '0;
    forever begin
      @(negedge clk);
      ba.bus_read_data = rd_a;
      if ((ba.bus_read || ba.bus_write) && !ba.bus_ready && cnt >= wait_a) ba.bus_ready = 1'b1;
      else ba.bus_ready = 1'b0;
      if (ba.bus_read || ba.bus_write) cnt++;
      else cnt = 0;
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    bb.bus_ready = 1'b0;
    bb.bus_read_data = '0;
    forever begin
      @(negedge clk);
      bb.bus_read_data = rd_b;
      if ((bb.bus_read || bb.bus_write) && !bb.bus_ready && cnt >= wait_b) bb.bus_ready = 1'b1;
      else bb.bus_ready = 1'b0;
      if (bb.bus_read || bb.bus_write) cnt++;
      else cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr_a();
    ra.req_address = '0; ra.req_store_data = '0; ra.req_size = '0;
    ra.req_signed = '0; ra.req_load = '0; ra.req_store = '0;
  endtask

  task automatic clr_b();
    rb.req_address = '0; rb.req_store_data = '0; rb.req_size = '0;
    rb.req_signed = '0; rb.req_load = '0; rb.req_store = '0;
  endtask

  task automatic set_a(input int ch, input logic ld, input logic st, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wd);
    ra.req_address[ch*32 +: 32]    = addr;
    ra.req_store_data[ch*32 +: 32] = wd;
    ra.req_size[ch*2 +: 2]         = size;
    ra.req_signed[ch]              = sgn;
    ra.req_load[ch]                = ld;
    ra.req_store[ch]               = st;
  endtask

  task automatic set_b(input int ch, input logic ld, input logic st, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wd);
    rb.req_address[ch*32 +: 32]    = addr;
    rb.req_store_data[ch*32 +: 32] = wd;
    rb.req_size[ch*2 +: 2]         = size;
    rb.req_signed[ch]              = sgn;
    rb.req_load[ch]                = ld;
    rb.req_store[ch]               = st;
  endtask

  typedef struct {
    int          ch;
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[13];

  // One transfer on u_a; called at a negedge with the DUT idle.
  task automatic run_vec_a(input int i, input vec_t v);
    bit saw_bus, done;
    int lat;
    saw_bus = 0; done = 0; lat = 0;
    rd_a = v.rdata; wait_a = v.waits;
    clr_a();
    set_a(v.ch, v.ld, v.st, v.addr, v.size, v.sgn, v.wdata);
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (!saw_bus && (ba.bus_read || ba.bus_write)) begin
        saw_bus = 1;
        chk($sformatf("v%0d_bus_read", i),  64'(ba.bus_read),       64'(!v.e_wr));
        chk($sformatf("v%0d_bus_write", i), 64'(ba.bus_write),      64'(v.e_wr));
        chk($sformatf("v%0d_bus_addr", i),  64'(ba.bus_address),    64'(v.e_addr));
        chk($sformatf("v%0d_strobe", i),    64'(ba.bus_strobe),     64'(v.e_strb));
        chk($sformatf("v%0d_wdata", i),     64'(ba.bus_write_data), 64'(v.e_wdata));
        chk($sformatf("v%0d_ld_busy", i),   64'(ra.req_load_data),  64'(0));
      end
      if (ra.req_ready != '0) begin
        done = 1; lat = c;
        chk($sformatf("v%0d_ready", i),   64'(ra.req_ready),     64'(2'b01 << v.ch));
        chk($sformatf("v%0d_error", i),   64'(ra.req_error),     v.err ? 64'(2'b01 << v.ch) : 64'(0));
        chk($sformatf("v%0d_ld_data", i), 64'(ra.req_load_data), 64'(v.e_load));
        chk($sformatf("v%0d_latency", i), 64'(lat),              v.err ? 64'(1) : 64'(2 + v.waits));
        clr_a();
      end
    end
    chk($sformatf("v%0d_ready_seen", i), 64'(done), 64'(1));
    chk($sformatf("v%0d_bus_used", i), 64'(saw_bus), v.err ? 64'(0) : 64'(1));
    @(negedge clk);
    chk($sformatf("v%0d_ready_pulse", i), 64'(ra.req_ready), 64'(0));
  endtask

  task automatic run_b(input string nm, input int ch, input logic ld, input logic st,
                       input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                       input logic [63:0] rdata, input logic [31:0] e_addr,
                       input logic [63:0] e_wdata, input logic [7:0] e_strb,
                       input logic [31:0] e_load);
    bit saw_bus, done;
    saw_bus = 0; done = 0;
    rd_b = rdata; wait_b = 0;
    clr_b();
    set_b(ch, ld, st, addr, size, 1'b0, wd);
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (!saw_bus && (bb.bus_read || bb.bus_write)) begin
        saw_bus = 1;
        chk({nm, "_addr"},  64'(bb.bus_address),    64'(e_addr));
        chk({nm, "_strb"},  64'(bb.bus_strobe),     64'(e_strb));
        chk({nm, "_wdata"}, 64'(bb.bus_write_data), e_wdata);
      end
      if (rb.req_ready != '0) begin
        done = 1;
        chk({nm, "_ready"}, 64'(rb.req_ready),     64'(3'b001 << ch));
        chk({nm, "_load"},  64'(rb.req_load_data), 64'(e_load));
        clr_b();
      end
    end
    chk({nm, "_done"}, 64'(done & saw_bus), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] order[$];
    logic [2:0] rr_seen[$];
    bit         w_seen, seen;
    int         late;

    vecs[0]  = '{0, 1'b1, 1'b0, 32'h103, SIZE_BYTE, 1'b1, 32'h0, 32'h80000000, 0,
                 1'b0, 1'b0, 32'h100, 32'h0, 4'h8, 32'hFFFFFF80};
    vecs[1]  = '{0, 1'b1, 1'b0, 32'h103, SIZE_BYTE, 1'b0, 32'h0, 32'h80000000, 1,
                 1'b0, 1'b0, 32'h100, 32'h0, 4'h8, 32'h00000080};
    vecs[2]  = '{1, 1'b0, 1'b1, 32'h102, SIZE_HALF, 1'b0, 32'h0000ABCD, 32'h0, 0,
                 1'b0, 1'b1, 32'h100, 32'hABCDABCD, 4'hC, 32'h0};
    vecs[3]  = '{1, 1'b0, 1'b1, 32'h200, SIZE_WORD, 1'b0, 32'h12345678, 32'h0, 2,
                 1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF, 32'h0};
    vecs[4]  = '{0, 1'b1, 1'b0, 32'h102, SIZE_HALF, 1'b1, 32'h0, 32'h80010000, 0,
                 1'b0, 1'b0, 32'h100, 32'h0, 4'hC, 32'hFFFF8001};
    vecs[5]  = '{0, 1'b1, 1'b0, 32'h100, SIZE_HALF, 1'b0, 32'h0, 32'h1234F00F, 3,
                 1'b0, 1'b0, 32'h100, 32'h0, 4'h3, 32'h0000F00F};
    vecs[6]  = '{1, 1'b1, 1'b0, 32'h204, SIZE_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 0,
                 1'b0, 1'b0, 32'h204, 32'h0, 4'hF, 32'hDEADBEEF};
    vecs[7]  = '{0, 1'b0, 1'b1, 32'h201, SIZE_BYTE, 1'b0, 32'hFFFFFF5A, 32'h0, 0,
                 1'b0, 1'b1, 32'h200, 32'h5A5A5A5A, 4'h2, 32'h0};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'h101, SIZE_BYTE, 1'b1, 32'h0, 32'h00007F00, 1,
                 1'b0, 1'b0, 32'h100, 32'h0, 4'h2, 32'h0000007F};
    vecs[9]  = '{0, 1'b1, 1'b0, 32'h102, SIZE_WORD, 1'b0, 32'h0, 32'h0, 0,
                 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[10] = '{1, 1'b0, 1'b1, 32'h101, SIZE_HALF, 1'b0, 32'h1234, 32'h0, 0,
                 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[11] = '{0, 1'b1, 1'b0, 32'h100, SIZE_RSVD, 1'b0, 32'h0, 32'h0, 0,
                 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{1, 1'b1, 1'b1, 32'h300, SIZE_WORD, 1'b0, 32'hCAFEF00D, 32'h99999999, 0,
                 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 32'h0};

    clr_a(); clr_b();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_a_ready",   64'(ra.req_ready),      64'(0));
    chk("rst_a_error",   64'(ra.req_error),      64'(0));
    chk("rst_a_load",    64'(ra.req_load_data),  64'(0));
    chk("rst_a_read",    64'(ba.bus_read),       64'(0));
    chk("rst_a_write",   64'(ba.bus_write),      64'(0));
    chk("rst_a_addr",    64'(ba.bus_address),    64'(0));
    chk("rst_a_wdata",   64'(ba.bus_write_data), 64'(0));
    chk("rst_a_strobe",  64'(ba.bus_strobe),     64'(0));
    chk("rst_b_ready",   64'(rb.req_ready),      64'(0));
    chk("rst_b_read",    64'(bb.bus_read),       64'(0));
    chk("rst_b_strobe",  64'(bb.bus_strobe),     64'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec_a(i, vecs[i]);

    // Contention on u_a: ch0 load and ch1 store in the same cycle.
    wait_a = 0; rd_a = 32'h11111111;
    w_seen = 0;
    clr_a();
    set_a(0, 1'b1, 1'b0, 32'h100, SIZE_WORD, 1'b0, 32'h0);
    set_a(1, 1'b0, 1'b1, 32'h200, SIZE_WORD, 1'b0, 32'h0BADF00D);
    for (int c = 0; c < 40 && order.size() < 2; c++) begin
      @(negedge clk);
      if (ba.bus_write && !w_seen) begin
        w_seen = 1;
        chk("cont_waddr", 64'(ba.bus_address),    64'(32'h200));
        chk("cont_wstrb", 64'(ba.bus_strobe),     64'(4'hF));
        chk("cont_wdata", 64'(ba.bus_write_data), 64'(32'h0BADF00D));
      end
      if (ra.req_ready != '0) begin
        if (order.size() == 0) chk("cont_load0", 64'(ra.req_load_data), 64'(32'h11111111));
        order.push_back(ra.req_ready);
        if (ra.req_ready[0]) set_a(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        if (ra.req_ready[1]) set_a(1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      end
    end
    chk("cont_count", 64'(order.size()), 64'(2));
    if (order.size() == 2) begin
      chk("cont_first",  64'(order[0]), 64'(2'b01));
      chk("cont_second", 64'(order[1]), 64'(2'b10));
    end
    chk("cont_write_seen", 64'(w_seen), 64'(1));
    clr_a();
    @(negedge clk);

    // Round-robin on u_b: all three channels held active.
    wait_b = 0; rd_b = 64'hAAAAAAAA_55555555;
    clr_b();
    for (int ch = 0; ch < 3; ch++) set_b(ch, 1'b1, 1'b0, 32'h100 + 32'(8*ch), SIZE_WORD, 1'b0, 32'h0);
    for (int c = 0; c < 60 && rr_seen.size() < 6; c++) begin
      @(negedge clk);
      if (rb.req_ready != '0) begin
        rr_seen.push_back(rb.req_ready);
        if (rr_seen.size() == 1) chk("rr_load", 64'(rb.req_load_data), 64'(32'h55555555));
      end
    end
    chk("rr_count", 64'(rr_seen.size()), 64'(6));
    for (int k = 0; k < rr_seen.size(); k++)
      chk($sformatf("rr_grant%0d", k), 64'(rr_seen[k]), 64'(3'b001 << (k % 3)));
    clr_b();
    @(negedge clk);
    @(negedge clk);

    // 64-bit lanes on u_b
    run_b("w64_load", 1, 1'b1, 1'b0, 32'h104, SIZE_WORD, 32'h0, 64'h11223344_55667788,
          32'h100, 64'h0, 8'hF0, 32'h11223344);
    run_b("w64_hstore", 2, 1'b0, 1'b1, 32'h106, SIZE_HALF, 32'h0000ABCD, 64'h0,
          32'h100, 64'hABCDABCD_ABCDABCD, 8'hC0, 32'h0);

    // Reset during an access with 5 wait states on u_a
    wait_a = 5; rd_a = 32'h77777777;
    seen = 0;
    clr_a();
    set_a(0, 1'b1, 1'b0, 32'h100, SIZE_WORD, 1'b0, 32'h0);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ba.bus_read) seen = 1;
    end
    chk("rstmid_read_seen", 64'(seen), 64'(1));
    repeat (2) @(negedge clk);
    chk("rstmid_still_busy", 64'(ba.bus_read), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("rstmid_read_drop", 64'(ba.bus_read),  64'(0));
    chk("rstmid_ready_low", 64'(ra.req_ready), 64'(0));
    clr_a();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    late = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ra.req_ready != '0 || ba.bus_read || ba.bus_write) late++;
    end
    chk("rstmid_no_ready_after", 64'(late), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/busio_arbiter.md
# busio_arbiter

Parametrised bus interface that arbitrates N pipeline request channels (fetch, load/store, and future DMA/debug ports) onto one downstream memory bus. It performs byte-lane alignment, store-strobe generation and load sign/zero extension. It sits between the pipeline top and the memory system, replacing the fixed two-port fetch/memory bus glue. It adds selectable round-robin arbitration and misalignment detection.

## Interface
- CHANNELS, 2, number of request channels (1..8); channel 0 is fetch by convention
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, bus data width (32 or 64)
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_address  in  CHANNELS*ADDR_WIDTH  byte address per channel
- req_store_data  in  CHANNELS*32  store data, right-aligned
- req_size  in  CHANNELS*2  0 byte, 1 half, 2 word, 3 reserved
- req_signed  in  CHANNELS  sign-extend loads
- req_load / req_store  in  CHANNELS each  request strobes, held until ready
- req_ready  out  CHANNELS  one-cycle completion pulse
- req_error  out  CHANNELS  one-cycle pulse with ready on misaligned/reserved size
- req_load_data  out  32  extended load result, valid with req_ready
- bus_address  out  ADDR_WIDTH  aligned to DATA_WIDTH/8
- bus_write_data  out  DATA_WIDTH  lane-replicated store data
- bus_strobe  out  DATA_WIDTH/8  byte enables
- bus_read / bus_write  out  1 each  held through access
- bus_read_data  in  DATA_WIDTH  sampled when bus_ready
- bus_ready  in  1  access complete, any number of wait states

## Operation
- A channel is active when req_load|req_store. Both set is treated as store.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE: if any channel is active, latch grant index, address, size, signed, data and direction.
  - Aligned request goes to ACCESS.
  - Misaligned request (half with addr[0], word with addr[1:0]≠0) or size 3 goes to RESPOND with error set.
- ACCESS: bus_read or bus_write are asserted from registered state. On bus_ready, capture aligned/extended read data and go to RESPOND.
- RESPOND: req_ready[grant]=1, req_error[grant]=error flag, req_load_data valid. Then return to IDLE.
- Fixed priority: lowest active index wins.
- Round-robin: search starts at last_grant+1 mod CHANNELS. last_grant updates only on entry to RESPOND.
- Load extraction: shift bus_read_data right by 8*offset, where offset = address mod (DATA_WIDTH/8). Zero-extend or sign-extend from bit 7/15 per size/signed. Word loads pass through.
- Store: data replicated into every lane of its size. Strobe = (1,3,F)<<offset.
- Request withdrawn during ACCESS: the bus transfer still completes and the ready pulse is still issued.
- Loads from non-granted channels are never forwarded. req_load_data = 0 outside RESPOND.

## Timing
- Reset: state IDLE, last_grant = CHANNELS-1, every output 0.
- Reset asserted mid-access drops bus_read/bus_write immediately (asynchronously), and no ready is issued.
- Latency: request seen in IDLE at cycle N. Bus strobes are asserted at N+1. With bus_ready at cycle M, req_ready is at M+1 and IDLE is at M+2.
- Zero-wait bus (bus_ready in the first ACCESS cycle): 3 cycles per transfer.
- Misaligned access: req_ready+req_error at N+1, no bus activity.
- The requester drops or changes its request in the cycle after req_ready. IDLE never re-grants a channel on the same cycle that channel's ready pulses.

## Structure
- busio_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state enum IDLE/ACCESS/RESPOND;
  - misalign check function.
- Sub-module bus_lane_align: combinational store replication/strobe generation and load shift/extend, parametrised on DATA_WIDTH.
- The arbiter FSM and grant logic stay in the top.

## Test plan
- CHANNELS=2, fixed priority: ch0 load 0x100 and ch1 store 0x200 in the same cycle → ch0 ready first, ch1 served next; bus_write at 0x200 with strobe 0xF.
- ROUND_ROBIN=1, CHANNELS=3, all channels continuously active → grant order 0,1,2,0,1,2.
- Signed byte load at 0x103, bus_read_data=0x80_00_00_00 → req_load_data=0xFFFFFF80. Unsigned load → 0x00000080.
- Half store 0xABCD to 0x102 → bus_write_data=0xABCDABCD, bus_strobe=0xC.
- DATA_WIDTH=64: word load at 0x104 → bus_address=0x100, data taken from the upper 32 bits.
- Misaligned word load at 0x102 → req_ready+req_error on the next cycle, bus_read never asserted.
- Reset asserted mid-ACCESS with 5 wait states → bus_read drops immediately; no ready is issued after reset release.
